gray_decoder_4bits: RTL
=======================

GRAY_DECODER_4BITS -- requirements
Module: gray_decoder_4bits

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit, SHALL be the system clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the synchronous active-low reset; 0 at a rising clk edge resets the block.
REQ-004 Port clk_en, input, 1 bit, SHALL be the decode-advance enable; 1 lets decode logic update.
REQ-005 Port gray_in, input, 4 bits, SHALL carry the Gray-coded position from an external gray_4bits-style source and may be asynchronous to clk.
REQ-006 Port bin_out, output, 4 bits, SHALL be the decoded binary position.
REQ-007 Port valid, output, 1 bit, SHALL indicate that bin_out holds a tracked position.
REQ-008 Port step, output, 1 bit, SHALL be a one-clock pulse for a legal ±1 transition.
REQ-009 Port dir_up, output, 1 bit, SHALL hold the direction of the last legal step: 1 = up, 0 = down.
REQ-010 Port err, output, 1 bit, SHALL be a one-clock pulse for an illegal transition.
REQ-011 Port err_cnt, output, 8 bits, SHALL hold the saturating count of illegal transitions.
REQ-012 Port pos, output, 8 bits, SHALL be the accumulated up/down step count, modulo 256.

Function
REQ-013 gray_in SHALL pass through a 2-flop synchronizer (sync1, sync2) every clock, independent of clk_en.
REQ-014 Decode SHALL be b[3]=g[3] and b[i]=b[i+1] XOR g[i] for i=2..0, with g = sync2.
REQ-015 FSM states SHALL be INIT, TRACK and RESYNC; all transitions and output updates other than the synchronizer SHALL occur only in cycles with clk_en=1.
REQ-016 INIT: on an enabled cycle, the block SHALL load bin_out=b, set valid=1 and go to TRACK; step, err and pos SHALL be unchanged.
REQ-017 TRACK: the block SHALL compute delta = (b - bin_out) mod 16 on 4 bits.
REQ-018 TRACK, delta=0: no output SHALL change, and step and err SHALL stay 0.
REQ-019 TRACK, delta=1: bin_out=b, step=1, dir_up=1, pos=pos+1 (wraps 255->0).
REQ-020 TRACK, delta=15: bin_out=b, step=1, dir_up=0, pos=pos-1 (wraps 0->255).
REQ-021 TRACK, any other delta: err=1, err_cnt=err_cnt+1 saturating at 255, valid=0, go to RESYNC; bin_out, pos and dir_up SHALL be unchanged.
REQ-022 RESYNC: on the next enabled cycle, the block SHALL load bin_out=b, set valid=1 and return to TRACK, with no step and no pos change.
REQ-023 step and err SHALL be 0 in every cycle where they are not pulsed, including every cycle with clk_en=0.
REQ-024 With clk_en held at 1, the latency from a gray_in change to the matching bin_out/step update SHALL be 3 rising edges (2 synchronizer + 1 decode).
REQ-025 With clk_en=0, all outputs SHALL hold; on re-enable, the single accumulated delta SHALL be judged per REQ-018..REQ-021, so a multi-step change while disabled counts as an error.
REQ-026 The 4-bit wrap SHALL be a legal step in both directions: binary 15->0 (Gray 1000->0000) is up, and 0->15 is down.

Reset
REQ-027 With rst=0 at a rising edge, the block SHALL clear sync1, sync2, bin_out, valid, step, dir_up, err, err_cnt and pos to 0 and set the state to INIT.
REQ-028 Reset SHALL take priority over clk_en and any in-progress transition.
REQ-029 Reset SHALL be legal mid-operation, including in RESYNC.
REQ-030 After rst returns to 1, the first enabled decode SHALL follow REQ-016, so pos restarts at 0 regardless of gray_in.

Verification
REQ-031 Reset, then gray_in=0000, clk_en=1 -> valid=1 at the 3rd edge after release; bin_out=0, pos=0; step and err never pulse.
REQ-032 gray_in 0000,0001,0011,0010,0110, each held 4 clocks -> bin_out 0,1,2,3,4; exactly 4 step pulses; dir_up=1; pos=4; err_cnt=0.
REQ-033 Wrap: bin_out=15 (gray 1000), then gray_in=0000 -> step, dir_up=1, bin_out=0; then gray_in=1000 -> step, dir_up=0, bin_out=15, pos returns to its prior value.
REQ-034 From gray 0000, jump to 0011 (bin 2) -> one err pulse, err_cnt=1, valid=0 for one enabled cycle, then bin_out=2, valid=1, pos unchanged; 300 such errors -> err_cnt=255.
REQ-035 clk_en=0 while gray_in goes 0000->0001->0011 -> outputs frozen, step=0; on clk_en=1 -> err pulse (delta=2) followed by resync to bin_out=2.
REQ-036 pos=5 in TRACK, rst=0 for 1 clock -> all outputs 0 at that edge, state INIT; the next enabled decode reloads bin_out with pos=0.

Source files
------------

// File: rtl/gray_decoder_4bits.sv
// rtl/gray_decoder_4bits.sv - synchronised 4-bit Gray position decoder with step/direction tracking
module gray_decoder_4bits (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [3:0] gray_in,
    output logic [3:0] bin_out,
    output logic       valid,
    output logic       step,
    output logic       dir_up,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [7:0] pos
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    state_t     state, nxt_state;
    logic [3:0] sync1, sync2;
    logic [1:0] sync_fill;
    logic [3:0] b;
    logic [3:0] delta;

    logic [3:0] nxt_bin;
    logic       nxt_valid;
    logic       nxt_step;
    logic       nxt_dir;
    logic       nxt_err;
    logic [7:0] nxt_err_cnt;
    logic [7:0] nxt_pos;

    // Synchroniser runs every cycle; sync_fill marks when sync2 holds a real sample
    // so the first load after reset reflects gray_in rather than the cleared flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1     <= 4'd0;
            sync2     <= 4'd0;
            sync_fill <= 2'b00;
        end else begin
            sync1     <= gray_in;
            sync2     <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    always_comb begin
        b[3] = sync2[3];
        b[2] = b[3] ^ sync2[2];
        b[1] = b[2] ^ sync2[1];
        b[0] = b[1] ^ sync2[0];
    end

    assign delta = b - bin_out;

    always_comb begin
        nxt_state   = state;
        nxt_bin     = bin_out;
        nxt_valid   = valid;
        nxt_step    = 1'b0;
        nxt_dir     = dir_up;
        nxt_err     = 1'b0;
        nxt_err_cnt = err_cnt;
        nxt_pos     = pos;
        if (clk_en) begin
            case (state)
                ST_INIT: begin
                    if (sync_fill[1]) begin
                        nxt_bin   = b;
                        nxt_valid = 1'b1;
                        nxt_state = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (delta == 4'd1) begin
                        nxt_bin  = b;
                        nxt_step = 1'b1;
                        nxt_dir  = 1'b1;
                        nxt_pos  = pos + 8'd1;
                    end else if (delta == 4'd15) begin
                        nxt_bin  = b;
                        nxt_step = 1'b1;
                        nxt_dir  = 1'b0;
                        nxt_pos  = pos - 8'd1;
                    end else if (delta != 4'd0) begin
                        nxt_err   = 1'b1;
                        nxt_valid = 1'b0;
                        nxt_state = ST_RESYNC;
                        if (err_cnt != 8'hFF) begin
                            nxt_err_cnt = err_cnt + 8'd1;
                        end
                    end
                end
                ST_RESYNC: begin
                    nxt_bin   = b;
                    nxt_valid = 1'b1;
                    nxt_state = ST_TRACK;
                end
                default: begin
                    nxt_state = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_INIT;
            bin_out <= 4'd0;
            valid   <= 1'b0;
            step    <= 1'b0;
            dir_up  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
            pos     <= 8'd0;
        end else begin
            state   <= nxt_state;
            bin_out <= nxt_bin;
            valid   <= nxt_valid;
            step    <= nxt_step;
            dir_up  <= nxt_dir;
            err     <= nxt_err;
            err_cnt <= nxt_err_cnt;
            pos     <= nxt_pos;
        end
    end

endmodule
